hs32_decode_stage: RTL and testbench
====================================

HS32_DECODE_STAGE -- requirements
Module: hs32_decode_stage

Interface
REQ-001 SHALL have parameter NSTG, default 2, meaning the number of downstream writer stages checked for hazards (range 1..4).
REQ-002 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rstn_i, input, 1 bit: asynchronous reset, active-low.
REQ-004 SHALL have port valid_i, input, 1 bit: data_i holds an instruction.
REQ-005 SHALL have port ready_o, output, 1 bit: the stage accepts data_i this cycle.
REQ-006 SHALL have port data_i, input, hs32_instr: fetched instruction.
REQ-007 SHALL have port rp_addr_o, output, 4 bits: regfile read address, always data_i rn field.
REQ-008 SHALL have port rp_data_i, input, 32 bits: combinational regfile read data.
REQ-009 SHALL have port wb_rd_i, input, NSTG x 4 bits: destination register of downstream stage k (k=0 is youngest).
REQ-010 SHALL have port wb_vld_i, input, NSTG bits: stage k writes wb_rd_i[k].
REQ-011 SHALL have port wb_fwd_i, input, NSTG bits: stage k result is forwardable this cycle.
REQ-012 SHALL have port flush_i, input, 1 bit: discard the held and incoming instruction.
REQ-013 SHALL have port valid_o, output, 1 bit: data_o is valid.
REQ-014 SHALL have port ready_i, input, 1 bit: downstream accepts data_o.
REQ-015 SHALL have port data_o, output, hs32_s1pkt_v2: registered decoded packet.

Function
REQ-016 Decode fields: rd, rm; d2 = rp_data_i for R-encoding (opcode[4]=1), else sign-extended imm; shl = R ? sh : 0; shr = R ? (ror ? 2's-complement of sh[4:0] : sh[4:0]) : 0; sext = (dir==2'b10); maskl = R ? ~ror : 1; maskr = R ? |dir : 0; opc = {opcode[5],opcode[3:0]}; ror = &dir.
REQ-017 Undefined-opcode flag xud SHALL be 0 for 0?_10??, 00_000?, 1?_0???, 1?_1010, 1?_1100, and 01_0000; 1 otherwise (01_0001..01_0011 included).
REQ-018 Hazard match k: R-encoding and wb_vld_i[k] and wb_rd_i[k]==rn.
REQ-019 Stall: the lowest matching k has wb_fwd_i[k]=0; older matches never override a younger one.
REQ-020 Forward: the lowest matching k has wb_fwd_i[k]=1; data_o.fwd=1 and data_o.fwd_sel=k, else fwd=0 and fwd_sel=0.
REQ-021 ready_o = ~stall & (~valid_o | ready_i) & ~flush_i.
REQ-022 Accept (valid_i & ready_o): packet registered, valid_o=1 next cycle; one-cycle latency.
REQ-023 Hold: valid_o & ~ready_i keeps data_o and valid_o stable.
REQ-024 Drain: ready_i with no accept clears valid_o next cycle (bubble on stall).
REQ-025 Flush: flush_i clears valid_o next cycle; dominates accept and hold.
REQ-026 Immediate-encoded instructions never stall or forward, regardless of wb_* inputs.

Reset
REQ-027 While rstn_i=0: valid_o=0, data_o all-zero, perf counter 0, asynchronously.
REQ-028 Reset mid-hold SHALL drop the held packet; first accept after release behaves as from idle.

Configuration
REQ-029 Macro HS32_DECODE_PERF_EN defined: extra output perf_stall_o, 32 bits, counts cycles with valid_i & stall & ~flush_i, saturates at 32'hFFFF_FFFF.
REQ-030 Macro undefined: port and counter absent; all other behaviour identical.

Structure
REQ-031 Shared types package SHALL hold hs32_s1pkt_v2 (hs32_s1pkt fields plus fwd_sel, 2 bits), HS32_NSTG_MAX=4, and the opcode-class constants.
REQ-032 Hazard priority logic SHALL be sub-module hs32_dec_hazard (inputs rn, renc, wb_*; outputs stall, fwd, fwd_sel).

Verification
REQ-033 Reset then valid_i with I-type imm=16'hFFF0, ready_i=1 -> next cycle valid_o=1, d2=32'hFFFF_FFF0, fwd=0.
REQ-034 R-type rn=5, wb_vld=2'b01, wb_rd[0]=5, wb_fwd=0 -> ready_o=0, valid_o=0 next cycle; set wb_fwd[0]=1 -> accepted, fwd=1, fwd_sel=0.
REQ-035 rn=3 matching stage0 (fwd=1) and stage1 (fwd=0) -> no stall, fwd_sel=0.
REQ-036 valid_o=1, ready_i=0 for 3 cycles -> data_o unchanged; flush_i pulse -> valid_o=0 next cycle, input not accepted.
REQ-037 Opcode sweep 6'h00..6'h3F -> xud matches REQ-017 table (01_0000 -> 0, 01_0001 -> 1).
REQ-038 With HS32_DECODE_PERF_EN, 7 stall cycles -> perf_stall_o=7; rstn_i low mid-hold -> valid_o=0, perf_stall_o=0 immediately.

Source files
------------

// File: rtl/hs32_decode_stage_pkg.sv
// ============================================================================
// Module : hs32_decode_stage_pkg
// Brief  : Shared instruction/packet types and opcode-class decode for the
//          HS32 decode stage.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package hs32_decode_stage_pkg;

  localparam int HS32_NSTG_MAX = 4;

  // Opcode classes
  localparam int         OPC_RENC_BIT = 4;
  localparam logic [1:0] DIR_SEXT     = 2'b10;
  localparam logic [1:0] DIR_ROR      = 2'b11;

  // R-encoding layout; an I-encoding reuses bits [15:0] as imm16.
  typedef struct packed {
    logic [5:0] opcode;
    logic [3:0] rd;
    logic [3:0] rm;
    logic [3:0] rn;
    logic [4:0] sh;
    logic [1:0] dir;
    logic [6:0] rsvd;
  } hs32_instr;

  typedef struct packed {
    logic [4:0]  opc;
    logic [3:0]  rd;
    logic [3:0]  rm;
    logic [31:0] d2;
    logic [4:0]  shl;
    logic [4:0]  shr;
    logic        sext;
    logic        maskl;
    logic        maskr;
    logic        xud;
    logic        fwd;
  } hs32_s1pkt;

  typedef struct packed {
    logic [4:0]  opc;
    logic [3:0]  rd;
    logic [3:0]  rm;
    logic [31:0] d2;
    logic [4:0]  shl;
    logic [4:0]  shr;
    logic        sext;
    logic        maskl;
    logic        maskr;
    logic        xud;
    logic        fwd;
    logic [1:0]  fwd_sel;
  } hs32_s1pkt_v2;

  function automatic logic hs32_xud(input logic [5:0] op);
    logic r;
    r = 1'b1;
    casez (op)
      6'b0?10??, 6'b00000?, 6'b1?0???,
      6'b1?1010, 6'b1?1100, 6'b010000: r = 1'b0;
      default:                          r = 1'b1;
    endcase
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hs32_dec_hazard.sv
// ============================================================================
// Module : hs32_dec_hazard
// Brief  : Read-after-write hazard priority; youngest matching writer decides
//          between stall and forward.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module hs32_dec_hazard #(
  parameter int NSTG = 2
) (
  input  logic [3:0]           rn_i,
  input  logic                 renc_i,
  input  logic [NSTG-1:0][3:0] wb_rd_i,
  input  logic [NSTG-1:0]      wb_vld_i,
  input  logic [NSTG-1:0]      wb_fwd_i,
  output logic                 stall_o,
  output logic                 fwd_o,
  output logic [1:0]           fwd_sel_o
);

  logic [NSTG-1:0] w_match;
  logic            w_found;

  for (genvar k = 0; k < NSTG; k++) begin : g_match
    assign w_match[k] = renc_i & wb_vld_i[k] & (wb_rd_i[k] == rn_i);
  end

  always_comb begin
    stall_o   = 1'b0;
    fwd_o     = 1'b0;
    fwd_sel_o = 2'd0;
    w_found   = 1'b0;
    for (int k = 0; k < NSTG; k++) begin
      if (!w_found && w_match[k]) begin
        w_found = 1'b1;
        if (wb_fwd_i[k]) begin
          fwd_o     = 1'b1;
          fwd_sel_o = 2'(k);
        end else begin
          stall_o = 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/hs32_decode_stage.sv
// ============================================================================
// Module : hs32_decode_stage
// Brief  : HS32 decode stage with operand hazard stall/forward and a
//          registered valid/ready output. Optional stall counter enabled by
//          macro HS32_DECODE_PERF_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module hs32_decode_stage
  import hs32_decode_stage_pkg::*;
#(
  parameter int NSTG = 2
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  hs32_instr            data_i,
  output logic [3:0]           rp_addr_o,
  input  logic [31:0]          rp_data_i,
  input  logic [NSTG-1:0][3:0] wb_rd_i,
  input  logic [NSTG-1:0]      wb_vld_i,
  input  logic [NSTG-1:0]      wb_fwd_i,
  input  logic                 flush_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output hs32_s1pkt_v2         data_o
`ifdef HS32_DECODE_PERF_EN
  ,
  output logic [31:0]          perf_stall_o
`endif
);

  logic         w_renc;
  logic         w_ror;
  logic [15:0]  w_imm;
  logic         w_stall;
  logic         w_fwd;
  logic [1:0]   w_fwd_sel;
  logic         w_accept;
  hs32_s1pkt_v2 w_pkt;

  logic         valid_q, valid_d;
  hs32_s1pkt_v2 data_q, data_d;

  assign w_renc    = data_i.opcode[OPC_RENC_BIT];
  assign w_ror     = (data_i.dir == DIR_ROR);
  assign w_imm     = {data_i.rn[1:0], data_i.sh, data_i.dir, data_i.rsvd};
  assign rp_addr_o = data_i.rn;

  hs32_dec_hazard #(
    .NSTG (NSTG)
  ) u_hazard (
    .rn_i      (data_i.rn),
    .renc_i    (w_renc),
    .wb_rd_i   (wb_rd_i),
    .wb_vld_i  (wb_vld_i),
    .wb_fwd_i  (wb_fwd_i),
    .stall_o   (w_stall),
    .fwd_o     (w_fwd),
    .fwd_sel_o (w_fwd_sel)
  );

  always_comb begin
    w_pkt         = '0;
    w_pkt.opc     = {data_i.opcode[5], data_i.opcode[3:0]};
    w_pkt.rd      = data_i.rd;
    w_pkt.rm      = data_i.rm;
    w_pkt.d2      = w_renc ? rp_data_i : {{16{w_imm[15]}}, w_imm};
    w_pkt.shl     = w_renc ? data_i.sh : 5'd0;
    // Right rotate by n is expressed as a right shift by (32 - n).
    w_pkt.shr     = w_renc ? (w_ror ? 5'(~data_i.sh + 5'd1) : data_i.sh) : 5'd0;
    w_pkt.sext    = (data_i.dir == DIR_SEXT);
    w_pkt.maskl   = w_renc ? ~w_ror : 1'b1;
    w_pkt.maskr   = w_renc ? |data_i.dir : 1'b0;
    w_pkt.xud     = hs32_xud(data_i.opcode);
    w_pkt.fwd     = w_fwd;
    w_pkt.fwd_sel = w_fwd ? w_fwd_sel : 2'd0;
  end

  assign ready_o  = ~w_stall & (~valid_q | ready_i) & ~flush_i;
  assign w_accept = valid_i & ready_o;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (w_accept) begin
      valid_d = 1'b1;
      data_d  = w_pkt;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

`ifdef HS32_DECODE_PERF_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (valid_i && w_stall && !flush_i && (perf_q != 32'hFFFF_FFFF)) begin
      perf_d = perf_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      perf_q <= 32'd0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_stall_o = perf_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hs32_decode_stage.sv
// ============================================================================
// Module : tb_hs32_decode_stage
// Brief  : Directed vector bench for hs32_decode_stage (NSTG=2).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_hs32_decode_stage;
  import hs32_decode_stage_pkg::*;

  logic             clk_i = 1'b0;
  logic             rstn_i;
  logic             valid_i;
  logic             ready_o;
  hs32_instr        data_i;
  logic [3:0]       rp_addr_o;
  logic [31:0]      rp_data_i;
  logic [1:0][3:0]  wb_rd_i;
  logic [1:0]       wb_vld_i;
  logic [1:0]       wb_fwd_i;
  logic             flush_i;
  logic             valid_o;
  logic             ready_i;
  hs32_s1pkt_v2     data_o;
  logic [31:0]      perf_stall_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  hs32_decode_stage #(
    .NSTG (2)
  ) dut (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .data_i    (data_i),
    .rp_addr_o (rp_addr_o),
    .rp_data_i (rp_data_i),
    .wb_rd_i   (wb_rd_i),
    .wb_vld_i  (wb_vld_i),
    .wb_fwd_i  (wb_fwd_i),
    .flush_i   (flush_i),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .data_o    (data_o)
`ifdef HS32_DECODE_PERF_EN
    ,
    .perf_stall_o (perf_stall_o)
`endif
  );

`ifndef HS32_DECODE_PERF_EN
  assign perf_stall_o = 32'd0;
`endif

  typedef struct {
    hs32_instr   instr;
    logic [31:0] rp;
    logic [7:0]  wrd;    // {stage1, stage0}
    logic [1:0]  wvld;
    logic [1:0]  wfwd;
    logic        rdy;
    logic [31:0] d2;
    logic [4:0]  shl;
    logic [4:0]  shr;
    logic [2:0]  flg;    // {sext, maskl, maskr}
    logic        fwd;
    logic [1:0]  sel;
  } vec_t;

  vec_t vecs[8];

  function automatic hs32_instr mk_i(input logic [5:0] op, input logic [3:0] rd,
                                     input logic [3:0] rm, input logic [15:0] imm);
    logic [31:0] w;
    w = {op, rd, rm, 2'b00, imm};
    return hs32_instr'(w);
  endfunction

  function automatic hs32_instr mk_r(input logic [5:0] op, input logic [3:0] rd,
                                     input logic [3:0] rm, input logic [3:0] rn,
                                     input logic [4:0] sh, input logic [1:0] dir);
    hs32_instr r;
    r = '{opcode: op, rd: rd, rm: rm, rn: rn, sh: sh, dir: dir, rsvd: 7'd0};
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    valid_i   = 1'b0;
    ready_i   = 1'b1;
    flush_i   = 1'b0;
    wb_rd_i   = '0;
    wb_vld_i  = '0;
    wb_fwd_i  = '0;
    rp_data_i = 32'd0;
  endtask

  logic [63:0] xud_tbl;
  logic [5:0]  op6;

  initial begin
    vecs[0] = '{mk_i(6'h00, 4'd1, 4'd2, 16'hFFF0), 32'h0, 8'h00, 2'b00, 2'b00,
                1'b1, 32'hFFFF_FFF0, 5'd0, 5'd0, 3'b010, 1'b0, 2'd0};
    vecs[1] = '{mk_i(6'h08, 4'd3, 4'd4, 16'h1234), 32'h0, 8'h00, 2'b11, 2'b00,
                1'b1, 32'h0000_1234, 5'd0, 5'd0, 3'b010, 1'b0, 2'd0};
    vecs[2] = '{mk_r(6'h10, 4'd5, 4'd6, 4'd7, 5'd3, 2'b11), 32'hDEAD_BEEF, 8'h00, 2'b00, 2'b00,
                1'b1, 32'hDEAD_BEEF, 5'd3, 5'd29, 3'b001, 1'b0, 2'd0};
    vecs[3] = '{mk_r(6'h11, 4'd1, 4'd2, 4'd3, 5'd10, 2'b10), 32'h0000_0042, 8'h33, 2'b11, 2'b01,
                1'b1, 32'h0000_0042, 5'd10, 5'd10, 3'b111, 1'b1, 2'd0};
    vecs[4] = '{mk_r(6'h12, 4'd7, 4'd8, 4'd9, 5'd31, 2'b00), 32'h1234_5678, 8'h92, 2'b11, 2'b10,
                1'b1, 32'h1234_5678, 5'd31, 5'd31, 3'b010, 1'b1, 2'd1};
    vecs[5] = '{mk_r(6'h13, 4'd0, 4'd0, 4'd4, 5'd0, 2'b01), 32'h0, 8'h40, 2'b10, 2'b00,
                1'b0, 32'h0, 5'd0, 5'd0, 3'b000, 1'b0, 2'd0};
    vecs[6] = '{mk_r(6'h1F, 4'd2, 4'd3, 4'd6, 5'd16, 2'b11), 32'h0, 8'h66, 2'b10, 2'b01,
                1'b0, 32'h0, 5'd0, 5'd0, 3'b000, 1'b0, 2'd0};
    vecs[7] = '{mk_r(6'h30, 4'd4, 4'd5, 4'd0, 5'd1, 2'b11), 32'hFFFF_FFFF, 8'h00, 2'b00, 2'b00,
                1'b1, 32'hFFFF_FFFF, 5'd1, 5'd31, 3'b001, 1'b0, 2'd0};
    xud_tbl = 64'hEB00_EB00_F0FE_F0FC;

    // Reset state
    idle_inputs();
    data_i = mk_i(6'h00, 4'd0, 4'd0, 16'h0);
    rstn_i = 1'b0;
    #7;
    chk("rst_valid_o", 64'(valid_o), 64'd0);
    chk("rst_data_o", 64'(data_o), 64'd0);
    chk("rst_perf", 64'(perf_stall_o), 64'd0);
    tick();
    tick();
    rstn_i = 1'b1;

    // I-type sign extension, one-cycle latency
    data_i  = mk_i(6'h00, 4'd1, 4'd2, 16'hFFF0);
    valid_i = 1'b1;
    #1;
    chk("itype_ready", 64'(ready_o), 64'd1);
    tick();
    valid_i = 1'b0;
    chk("itype_valid", 64'(valid_o), 64'd1);
    chk("itype_d2", 64'(data_o.d2), 64'hFFFF_FFF0);
    chk("itype_fwd", 64'(data_o.fwd), 64'd0);
    tick();
    chk("drain_valid", 64'(valid_o), 64'd0);

    // Stall on non-forwardable youngest writer, then release via forward
    data_i    = mk_r(6'h10, 4'd1, 4'd2, 4'd5, 5'd0, 2'b00);
    rp_data_i = 32'hCAFE_0005;
    valid_i   = 1'b1;
    wb_vld_i  = 2'b01;
    wb_rd_i   = 8'h05;
    wb_fwd_i  = 2'b00;
    #1;
    chk("stall_ready", 64'(ready_o), 64'd0);
    repeat (7) tick();
    chk("stall_valid", 64'(valid_o), 64'd0);
`ifdef HS32_DECODE_PERF_EN
    chk("perf_7", 64'(perf_stall_o), 64'd7);
`endif
    wb_fwd_i = 2'b01;
    #1;
    chk("fwd_ready", 64'(ready_o), 64'd1);
    tick();
    chk("fwd_valid", 64'(valid_o), 64'd1);
    chk("fwd_flag", 64'(data_o.fwd), 64'd1);
    chk("fwd_sel", 64'(data_o.fwd_sel), 64'd0);
    chk("fwd_d2", 64'(data_o.d2), 64'hCAFE_0005);
    idle_inputs();

    // Vector table
    for (int i = 0; i < 8; i++) begin
      data_i    = vecs[i].instr;
      rp_data_i = vecs[i].rp;
      wb_rd_i   = vecs[i].wrd;
      wb_vld_i  = vecs[i].wvld;
      wb_fwd_i  = vecs[i].wfwd;
      valid_i   = 1'b1;
      ready_i   = 1'b1;
      #1;
      chk($sformatf("v%0d_ready", i), 64'(ready_o), 64'(vecs[i].rdy));
      tick();
      chk($sformatf("v%0d_valid", i), 64'(valid_o), 64'(vecs[i].rdy));
      if (vecs[i].rdy) begin
        chk($sformatf("v%0d_d2", i), 64'(data_o.d2), 64'(vecs[i].d2));
        chk($sformatf("v%0d_shift", i), 64'({data_o.shl, data_o.shr}),
            64'({vecs[i].shl, vecs[i].shr}));
        chk($sformatf("v%0d_flags", i), 64'({data_o.sext, data_o.maskl, data_o.maskr}),
            64'(vecs[i].flg));
        chk($sformatf("v%0d_fwd", i), 64'({data_o.fwd, data_o.fwd_sel}),
            64'({vecs[i].fwd, vecs[i].sel}));
        chk($sformatf("v%0d_regs", i), 64'({data_o.rd, data_o.rm}),
            64'({vecs[i].instr.rd, vecs[i].instr.rm}));
      end
    end
    idle_inputs();
    tick();

    // Hold for 3 cycles, then flush
    data_i  = mk_i(6'h01, 4'hA, 4'hB, 16'h7ABC);
    valid_i = 1'b1;
    tick();
    data_i  = mk_i(6'h02, 4'h1, 4'h1, 16'h0001);
    ready_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("hold_ready", 64'(ready_o), 64'd0);
      tick();
      chk("hold_valid", 64'(valid_o), 64'd1);
      chk("hold_data", 64'({data_o.rd, data_o.d2}), 64'({4'hA, 32'h0000_7ABC}));
    end
    flush_i = 1'b1;
    #1;
    chk("flush_ready", 64'(ready_o), 64'd0);
    tick();
    flush_i = 1'b0;
    chk("flush_valid", 64'(valid_o), 64'd0);

    // Flush dominates an otherwise possible accept
    ready_i = 1'b1;
    flush_i = 1'b1;
    #1;
    chk("flush_acc_ready", 64'(ready_o), 64'd0);
    tick();
    flush_i = 1'b0;
    chk("flush_acc_valid", 64'(valid_o), 64'd0);
    idle_inputs();

    // Asynchronous reset while holding
    data_i  = mk_i(6'h01, 4'hA, 4'hB, 16'h7ABC);
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    ready_i = 1'b0;
    tick();
    #2;
    rstn_i = 1'b0;
    #1;
    chk("midrst_valid", 64'(valid_o), 64'd0);
    chk("midrst_data", 64'(data_o), 64'd0);
    chk("midrst_perf", 64'(perf_stall_o), 64'd0);
    tick();
    rstn_i  = 1'b1;
    data_i  = mk_i(6'h02, 4'h1, 4'h1, 16'h0001);
    valid_i = 1'b1;
    ready_i = 1'b1;
    #1;
    chk("postrst_ready", 64'(ready_o), 64'd1);
    tick();
    chk("postrst_valid", 64'(valid_o), 64'd1);
    chk("postrst_d2", 64'(data_o.d2), 64'd1);
    idle_inputs();

    // Opcode sweep
    for (int op = 0; op < 64; op++) begin
      op6     = 6'(op);
      data_i  = mk_i(op6, 4'd0, 4'd0, 16'h0000);
      valid_i = 1'b1;
      tick();
      chk($sformatf("xud_op%02h", op), 64'(data_o.xud), 64'(xud_tbl[op]));
      chk($sformatf("opc_op%02h", op), 64'(data_o.opc), 64'({op6[5], op6[3:0]}));
    end
    idle_inputs();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
